// File: rtl/usb_eps_arb.sv
// Single-port EP status RAM arbiter: transaction engine > bus > clear sweep, one access per cycle.
// Command registered (op+1), read data registered once (op+3); bus waits for bus_ack, sweep stalls on lost slots.
module usb_eps_arb #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          eps_read_0,
  input  logic          eps_zero_0,
  input  logic          eps_write_0,
  input  logic [AW-1:0] eps_addr_0,
  input  logic [DW-1:0] eps_wrdata_0,
  output logic [DW-1:0] eps_rddata_3,
  input  logic          bus_req,
  input  logic          bus_we,
  input  logic [AW-1:0] bus_addr,
  input  logic [DW-1:0] bus_wdata,
  output logic          bus_ack,
  output logic          bus_rvalid,
  output logic [DW-1:0] bus_rdata,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_re,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {TAG_NONE, TAG_TRANS, TAG_BUS} tag_e;
  typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_e;

  typedef struct packed {
    logic          re;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } ram_cmd_t;

  ram_cmd_t   cmd_d, cmd_q;
  tag_e       tag0_d, tag0_q, tag1_q, tag2_q;
  clr_state_e clr_state_d, clr_state_q;
  logic [AW-1:0] clr_cnt_d, clr_cnt_q;
  logic [DW-1:0] eps_rddata_d, eps_rddata_q;
  logic [DW-1:0] bus_rdata_d, bus_rdata_q;
  logic       ack_prev_d, ack_prev_q;
  logic       trans_op, trans_wr, clr_grant;

  assign trans_op = eps_read_0 | eps_zero_0 | eps_write_0;
  assign trans_wr = eps_zero_0 | eps_write_0;

  // The cycle after a grant the requester may still show bus_req; it is not a new request.
  assign bus_ack    = rst_n & bus_req & ~trans_op & ~ack_prev_q;
  assign ack_prev_d = bus_ack;
  assign clr_grant  = (clr_state_q == CLR_RUN) & ~trans_op & ~bus_ack;

  always_comb begin
    cmd_d       = '0;
    tag0_d      = TAG_NONE;
    clr_state_d = clr_state_q;
    clr_cnt_d   = clr_cnt_q;

    if (trans_op) begin
      cmd_d.we    = trans_wr;
      cmd_d.re    = ~trans_wr;
      cmd_d.addr  = eps_addr_0;
      cmd_d.wdata = eps_zero_0 ? '0 : eps_wrdata_0;
      tag0_d      = trans_wr ? TAG_NONE : TAG_TRANS;
    end else if (bus_ack) begin
      cmd_d.we    = bus_we;
      cmd_d.re    = ~bus_we;
      cmd_d.addr  = bus_addr;
      cmd_d.wdata = bus_wdata;
      tag0_d      = bus_we ? TAG_NONE : TAG_BUS;
    end else if (clr_grant) begin
      cmd_d.we    = 1'b1;
      cmd_d.addr  = clr_cnt_q;
    end

    case (clr_state_q)
      CLR_IDLE: begin
        if (clr_start) begin
          clr_state_d = CLR_RUN;
          clr_cnt_d   = '0;
        end
      end
      CLR_RUN: begin
        if (clr_grant) begin
          clr_cnt_d = clr_cnt_q + AW'(1);
          // Single pass: stop after the top address instead of wrapping.
          if (clr_cnt_q == {AW{1'b1}}) clr_state_d = CLR_IDLE;
        end
      end
      default: clr_state_d = CLR_IDLE;
    endcase

    eps_rddata_d = (tag1_q == TAG_TRANS) ? ram_rdata : eps_rddata_q;
    bus_rdata_d  = (tag1_q == TAG_BUS)   ? ram_rdata : bus_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q        <= '0;
      tag0_q       <= TAG_NONE;
      tag1_q       <= TAG_NONE;
      tag2_q       <= TAG_NONE;
      clr_state_q  <= CLR_IDLE;
      clr_cnt_q    <= '0;
      eps_rddata_q <= '0;
      bus_rdata_q  <= '0;
      ack_prev_q   <= 1'b0;
    end else begin
      cmd_q        <= cmd_d;
      tag0_q       <= tag0_d;
      tag1_q       <= tag0_q;
      tag2_q       <= tag1_q;
      clr_state_q  <= clr_state_d;
      clr_cnt_q    <= clr_cnt_d;
      eps_rddata_q <= eps_rddata_d;
      bus_rdata_q  <= bus_rdata_d;
      ack_prev_q   <= ack_prev_d;
    end
  end

  assign ram_re       = cmd_q.re;
  assign ram_we       = cmd_q.we;
  assign ram_addr     = cmd_q.addr;
  assign ram_wdata    = cmd_q.wdata;
  assign eps_rddata_3 = eps_rddata_q;
  assign bus_rdata    = bus_rdata_q;
  assign bus_rvalid   = (tag2_q == TAG_BUS);
  assign clr_busy     = (clr_state_q == CLR_RUN);

endmodule

// File: tb/tb_usb_eps_arb.sv
// Directed bench for usb_eps_arb with a behavioural 256x16 RAM and read-data scoreboards.
module tb_usb_eps_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        eps_read_0, eps_zero_0, eps_write_0;
  logic [7:0]  eps_addr_0;
  logic [15:0] eps_wrdata_0, eps_rddata_3;
  logic        bus_req, bus_we, bus_ack, bus_rvalid;
  logic [7:0]  bus_addr;
  logic [15:0] bus_wdata, bus_rdata;
  logic        clr_start, clr_busy;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata, ram_rdata;
  logic        ram_re, ram_we;

  usb_eps_arb #(.AW(8), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .eps_read_0(eps_read_0), .eps_zero_0(eps_zero_0), .eps_write_0(eps_write_0),
    .eps_addr_0(eps_addr_0), .eps_wrdata_0(eps_wrdata_0), .eps_rddata_3(eps_rddata_3),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_re(ram_re), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        trans_q[$];
  exp_t        bus_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic        mem_load;
  logic [15:0] mem [256];

  function automatic logic [15:0] exp_init(input int a);
    logic [15:0] v;
    v = (16'(a) * 16'h0101) ^ 16'hA5A5;
    if (a == 8'h25) v = 16'hBEEF;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read data valid exactly one cycle after ram_re, junk otherwise.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int a = 0; a < 256; a++) mem[a] <= exp_init(a);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= ram_re ? mem[ram_addr] : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (trans_q.size() > 0 && cyc == trans_q[0].due) begin
      check("eps_rddata_3", 32'(eps_rddata_3), 32'(trans_q[0].data));
      void'(trans_q.pop_front());
    end
    if (bus_rvalid) begin
      check("bus_rvalid_expected", 32'(bus_q.size() != 0), 32'd1);
      if (bus_q.size() != 0) begin
        check("bus_rvalid_cycle", cyc, bus_q[0].due);
        check("bus_rdata", 32'(bus_rdata), 32'(bus_q[0].data));
        void'(bus_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trans_read(input logic [7:0] a, input logic [15:0] exp);
    eps_read_0 = 1'b1;
    eps_addr_0 = a;
    trans_q.push_back('{exp, cyc + 3});
    tick();
    eps_read_0 = 1'b0;
  endtask

  task automatic bus_op(input logic we, input logic [7:0] a, input logic [15:0] d,
                        input logic [15:0] exp, output int ack_cyc);
    bus_req   = 1'b1;
    bus_we    = we;
    bus_addr  = a;
    bus_wdata = d;
    ack_cyc   = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus_ack) begin
        ack_cyc = cyc;
        break;
      end
      tick();
    end
    if (ack_cyc < 0) check("bus_ack_timeout", 32'd0, 32'd1);
    else if (!we) bus_q.push_back('{exp, ack_cyc + 3});
    tick();
    bus_req = 1'b0;
  endtask

  initial begin
    int m, rc, s, done, wr_cnt, bad;
    rst_n = 1'b0; mem_load = 1'b1;
    eps_read_0 = 0; eps_zero_0 = 0; eps_write_0 = 0; eps_addr_0 = '0; eps_wrdata_0 = '0;
    bus_req = 0; bus_we = 0; bus_addr = '0; bus_wdata = '0; clr_start = 0;

    // Reset state
    tick(); tick();
    @(negedge clk);
    check("reset_ctl", 32'({ram_re, ram_we, bus_ack, bus_rvalid, clr_busy}), 32'd0);
    check("reset_eps_rddata", 32'(eps_rddata_3), 32'd0);
    check("reset_bus_rdata", 32'(bus_rdata), 32'd0);
    tick();
    rst_n = 1'b1; mem_load = 1'b0;

    // Transaction read at cycle 10
    while (cyc < 10) tick();
    trans_read(8'h25, 16'hBEEF);
    check("trans_rd_cmd", 32'({ram_re, ram_we, ram_addr}), 32'({1'b1, 1'b0, 8'h25}));
    repeat (4) tick();

    // Zero-write beats write data
    eps_zero_0 = 1; eps_write_0 = 1; eps_addr_0 = 8'h10; eps_wrdata_0 = 16'h1234;
    tick();
    eps_zero_0 = 0; eps_write_0 = 0;
    check("zero_cmd", 32'({ram_re, ram_we, ram_addr, ram_wdata}), 32'({1'b0, 1'b1, 8'h10, 16'h0000}));
    // Write beats read
    eps_write_0 = 1; eps_read_0 = 1; eps_addr_0 = 8'h11; eps_wrdata_0 = 16'h5A5A;
    tick();
    eps_write_0 = 0; eps_read_0 = 0;
    check("wr_over_rd_cmd", 32'({ram_re, ram_we, ram_wdata}), 32'({1'b0, 1'b1, 16'h5A5A}));
    trans_read(8'h10, 16'h0000);
    trans_read(8'h11, 16'h5A5A);
    repeat (4) tick();

    // Bus read blocked by three transaction writes
    bus_req = 1; bus_we = 0; bus_addr = 8'h40;
    for (int k = 0; k < 3; k++) begin
      eps_write_0 = 1; eps_addr_0 = 8'h50 + 8'(k); eps_wrdata_0 = 16'h1111;
      @(negedge clk);
      check("bus_ack_blocked", 32'(bus_ack), 32'd0);
      tick();
    end
    eps_write_0 = 0;
    @(negedge clk);
    check("bus_ack_4th", 32'(bus_ack), 32'd1);
    m = cyc;
    bus_q.push_back('{exp_init(8'h40), m + 3});
    tick();
    @(negedge clk);
    check("bus_req_held_no_regrant", 32'(bus_ack), 32'd0);
    check("bus_rd_cmd", 32'({ram_re, ram_addr}), 32'({1'b1, 8'h40}));
    tick();
    bus_req = 0;
    repeat (4) tick();

    // Bus write then read back; bus_rdata holds across trans reads
    rc = cyc;
    bus_op(1'b1, 8'h41, 16'hCAFE, 16'h0, m);
    check("bus_ack_immediate", m, rc);
    bus_op(1'b0, 8'h41, 16'h0, 16'hCAFE, m);
    repeat (4) tick();
    trans_read(8'h60, exp_init(8'h60));
    repeat (4) tick();
    check("bus_rdata_hold", 32'(bus_rdata), 32'hCAFE);

    // Clear sweep with interleaved trans read, bus write and ignored restart
    clr_start = 1; s = cyc;
    done = -1; wr_cnt = 0;
    for (int i = 1; i < 600; i++) begin
      tick();
      clr_start  = (i == 100);
      eps_read_0 = (i == 4);
      eps_addr_0 = 8'h80;
      if (i == 4) trans_q.push_back('{exp_init(8'h80), cyc + 3});
      bus_req = (i == 20); bus_we = 1; bus_addr = 8'h03; bus_wdata = 16'h4321;
      @(negedge clk);
      if (i == 1) check("clr_busy_set", 32'(clr_busy), 32'd1);
      if (i == 20) check("clr_bus_ack", 32'(bus_ack), 32'd1);
      if (ram_we) wr_cnt++;
      if (!clr_busy) begin
        done = cyc;
        break;
      end
    end
    tick();
    clr_start = 0; eps_read_0 = 0; bus_req = 0;
    check("clr_done_cycle", done, s + 259);
    check("clr_write_count", wr_cnt, 257);
    repeat (3) tick();
    @(negedge clk);
    check("clr_no_second_pass", 32'({clr_busy, ram_we}), 32'd0);
    bad = 0;
    for (int a = 0; a < 256; a++)
      if (mem[a] !== ((a == 3) ? 16'h4321 : 16'h0000)) bad++;
    check("ram_after_clear", bad, 0);
    tick();
    trans_read(8'h03, 16'h4321);
    trans_read(8'hFF, 16'h0000);
    repeat (5) tick();

    // Reset between bus grant and bus_rvalid
    bus_op(1'b0, 8'h30, 16'h0, 16'h0, m);
    rst_n = 1'b0;
    bus_q.delete();
    @(negedge clk);
    check("rst_mid_ctl", 32'({ram_re, ram_we, bus_ack, bus_rvalid, clr_busy}), 32'd0);
    check("rst_mid_data", 32'({eps_rddata_3, bus_rdata}), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("post_rst_outputs", 32'({ram_re, ram_we, bus_ack, bus_rvalid, clr_busy, ram_addr}), 32'd0);
    check("post_rst_data", 32'({eps_rddata_3, bus_rdata}), 32'd0);
    check("trans_q_drained", trans_q.size(), 0);
    check("bus_q_drained", bus_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_eps_arb.md
USB_EPS_ARB -- requirements
Module: usb_eps_arb

Interface
REQ-001 SHALL have parameter AW, default 8: EP status RAM address width.
REQ-002 SHALL have parameter DW, default 16: EP status RAM data width.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have ports eps_read_0, eps_zero_0, eps_write_0, input, 1 each: transaction-engine read, zero-write and write strobes.
REQ-006 SHALL have ports eps_addr_0 (input, AW) and eps_wrdata_0 (input, DW): transaction-engine address and write data.
REQ-007 SHALL have port eps_rddata_3, output, DW: transaction-engine read data.
REQ-008 SHALL have ports bus_req, bus_we, input, 1 each: bus request and bus write select.
REQ-009 SHALL have ports bus_addr (input, AW) and bus_wdata (input, DW): bus address and write data.
REQ-010 SHALL have ports bus_ack, output, 1 (grant pulse) and bus_rvalid, output, 1 (read-data-valid pulse).
REQ-011 SHALL have port bus_rdata, output, DW: bus read data.
REQ-012 SHALL have ports clr_start (input, 1: start full clear) and clr_busy (output, 1: clear in progress).
REQ-013 SHALL have ports ram_addr (output, AW), ram_wdata (output, DW), ram_re (output, 1), ram_we (output, 1): single-port RAM command, all registered.
REQ-014 SHALL have port ram_rdata, input, DW: RAM read data, valid exactly 1 cycle after ram_re.

Function
REQ-015 SHALL grant one RAM access per cycle with fixed priority: transaction engine > bus > clear sweep.
REQ-016 SHALL treat a transaction op in cycle N (any eps_*_0 high) as always granted; the command appears on ram_* in cycle N+1.
REQ-017 SHALL return transaction read data on eps_rddata_3 in cycle N+3, i.e. ram_rdata registered once.
REQ-018 SHALL, for eps_zero_0, drive ram_we=1 with ram_wdata=0 regardless of eps_wrdata_0; eps_zero_0 takes precedence over eps_write_0, and any write over eps_read_0.
REQ-019 SHALL assert bus_ack for one cycle in a cycle where bus_req=1, no transaction op is present and bus_ack was low in the previous cycle; the command issues on ram_* the next cycle.
REQ-020 SHALL require the requester to hold bus_req, bus_we, bus_addr and bus_wdata stable until bus_ack; bus_req sampled in the bus_ack cycle is not a new request.
REQ-021 SHALL, for a granted bus read in cycle M, pulse bus_rvalid in cycle M+3 with bus_rdata holding the RAM data; bus_rdata holds its value until the next bus read completes.
REQ-022 SHALL track read ownership with a 3-stage tag pipeline (none/trans/bus); eps_rddata_3 updates only on trans-tagged reads, bus_rdata only on bus-tagged reads.
REQ-023 SHALL, on clr_start while idle, set clr_busy the next cycle and clear an AW-bit counter to 0.
REQ-024 SHALL, when clr_busy and neither higher-priority requester uses the slot, issue a write of 0 to the counter address and increment the counter.
REQ-025 SHALL deassert clr_busy the cycle after address 2^AW-1 is written; the counter does not wrap into a second pass.
REQ-026 SHALL ignore clr_start while clr_busy is set.
REQ-027 SHALL drive ram_re=ram_we=0 in cycles with no grant; ram_addr and ram_wdata are don't-care then.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force ram_re, ram_we, bus_ack, bus_rvalid, clr_busy to 0, the tag pipeline to none, and the clear counter to 0.
REQ-029 SHALL reset eps_rddata_3 and bus_rdata to 0.
REQ-030 SHALL drop reads in flight at reset; no bus_rvalid is produced for them after release.

Verification
REQ-031 SHALL cover: eps_read_0 addr 0x25 in cycle 10, RAM[0x25]=0xBEEF -> ram_re/addr 0x25 in cycle 11, eps_rddata_3=0xBEEF in cycle 13.
REQ-032 SHALL cover: bus read addr 0x40 concurrent with eps_write_0 for 3 cycles -> bus_ack in 4th cycle, bus_rvalid 3 cycles later with RAM[0x40].
REQ-033 SHALL cover: eps_zero_0 and eps_write_0 together, addr 0x10, wrdata 0x1234 -> RAM[0x10]=0x0000.
REQ-034 SHALL cover: clr_start with a bus write and a trans read interleaved -> all 256 entries 0 except the bus-written one if written after its sweep slot; clr_busy low after 256 sweep writes plus stall cycles.
REQ-035 SHALL cover: rst_n low for 1 cycle between a bus grant and its bus_rvalid -> no bus_rvalid after release, all outputs 0.
REQ-036 SHALL cover: clr_start pulsed again mid-sweep -> ignored, sweep finishes exactly once.
